// File: rtl/ex_mem_skid.sv
// EX/MEM pipeline stage with valid/ready flow control and a two-entry skid buffer.
// in_ready is registered; bubbles present all-zero control so MEM sees a NOP.
module ex_mem_skid #(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 72,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic main_valid;
  logic push;
  logic pop;

  assign main_valid = (state_q != S_EMPTY);
  assign push       = in_valid & in_ready_q;
  assign pop        = main_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (push) begin
            state_d     = S_ONE;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end
        end
        S_ONE: begin
          if (push) begin
            if (pop) begin
              main_ctrl_d = in_ctrl;
              main_data_d = in_data;
            end else begin
              state_d     = S_TWO;
              skid_ctrl_d = in_ctrl;
              skid_data_d = in_data;
            end
          end else if (pop) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            state_d     = S_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  assign in_ready_d = (state_d != S_TWO);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (main_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_EMPTY;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b1;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl_q & {CTRL_W{main_valid}};
  assign out_data  = main_data_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid.sv
// Directed bench for ex_mem_skid: streaming, backpressure, flush, bubble gating,
// counter saturation (CNT_W=4) and asynchronous reset in the middle of traffic.
module tb_ex_mem_skid;

  localparam int CTRL_W = 8;
  localparam int DATA_W = 72;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  stall_cnt;

  int checks = 0;
  int errors = 0;

  ex_mem_skid #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_ctrl  (in_ctrl),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_ctrl (out_ctrl),
    .out_data (out_data),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, '0);
    #12;
    check("rst_out_valid", DATA_W'(out_valid), 72'd0);
    check("rst_in_ready",  DATA_W'(in_ready),  72'd1);
    check("rst_out_ctrl",  DATA_W'(out_ctrl),  72'd0);
    check("rst_out_data",  out_data,           72'd0);
    check("rst_stall",     DATA_W'(stall_cnt), 72'd0);
    rst_n = 1'b1;
    #2;

    // Streaming with out_ready=1
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, 8'h05, DATA_W'(i));
      step();
      check($sformatf("stream_valid_%0d", i), DATA_W'(out_valid), 72'd1);
      check($sformatf("stream_data_%0d", i),  out_data,           DATA_W'(i));
      check($sformatf("stream_ctrl_%0d", i),  DATA_W'(out_ctrl),  72'h05);
      check($sformatf("stream_rdy_%0d", i),   DATA_W'(in_ready),  72'd1);
    end
    drive(1'b0, 8'h00, '0);
    step();
    check("stream_drain_valid", DATA_W'(out_valid), 72'd0);
    check("stream_stall",       DATA_W'(stall_cnt), 72'd0);

    // Backpressure: 1 in main, 2 in skid, 3 held by EX
    out_ready = 1'b0;
    drive(1'b1, 8'h11, 72'd1);
    step();
    check("bp_main1", out_data, 72'd1);
    drive(1'b1, 8'h11, 72'd2);
    step();
    check("bp_rdy_low", DATA_W'(in_ready), 72'd0);
    check("bp_main1b",  out_data,          72'd1);
    drive(1'b1, 8'h11, 72'd3);
    step();
    check("bp_hold_data", out_data,          72'd1);
    check("bp_hold_rdy",  DATA_W'(in_ready), 72'd0);
    check("bp_stall",     DATA_W'(stall_cnt), 72'd2);
    out_ready = 1'b1;
    step();
    check("bp_out2",     out_data,          72'd2);
    check("bp_rdy_back", DATA_W'(in_ready), 72'd1);
    step();
    check("bp_out3", out_data, 72'd3);
    drive(1'b0, 8'h00, '0);
    step();
    check("bp_empty",       DATA_W'(out_valid), 72'd0);
    check("bp_stall_final", DATA_W'(stall_cnt), 72'd2);

    // Flush in TWO with a push presented
    out_ready = 1'b0;
    drive(1'b1, 8'h33, 72'hA1);
    step();
    drive(1'b1, 8'h33, 72'hA2);
    step();
    check("fl_two_rdy", DATA_W'(in_ready), 72'd0);
    drive(1'b1, 8'h33, 72'hA3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", DATA_W'(out_valid), 72'd0);
    check("fl_ctrl",  DATA_W'(out_ctrl),  72'd0);
    check("fl_rdy",   DATA_W'(in_ready),  72'd1);
    check("fl_stall", DATA_W'(stall_cnt), 72'd4);
    drive(1'b0, 8'h00, '0);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("fl_no_ghost_%0d", i), DATA_W'(out_valid), 72'd0);
    end

    // Bubble gating after main held ctrl 0xFF
    drive(1'b1, 8'hFF, 72'h77);
    step();
    check("bub_ctrl_full", DATA_W'(out_ctrl), 72'hFF);
    drive(1'b0, 8'h00, '0);
    step();
    check("bub_valid", DATA_W'(out_valid), 72'd0);
    check("bub_ctrl",  DATA_W'(out_ctrl),  72'd0);

    // Stall counter saturation
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 72'h99);
    step();
    drive(1'b0, 8'h00, '0);
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", DATA_W'(stall_cnt), 72'd15);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("sat_after_flush", DATA_W'(stall_cnt), 72'd15);
    check("sat_flush_valid", DATA_W'(out_valid), 72'd0);

    // Asynchronous reset while in TWO
    drive(1'b1, 8'h44, 72'hB1);
    step();
    drive(1'b1, 8'h44, 72'hB2);
    step();
    check("ar_two_rdy", DATA_W'(in_ready), 72'd0);
    drive(1'b0, 8'h00, '0);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", DATA_W'(out_valid), 72'd0);
    check("ar_ctrl",  DATA_W'(out_ctrl),  72'd0);
    check("ar_data",  out_data,           72'd0);
    check("ar_rdy",   DATA_W'(in_ready),  72'd1);
    check("ar_stall", DATA_W'(stall_cnt), 72'd0);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 8'h22, 72'h55);
    step();
    check("ar_first_push_valid", DATA_W'(out_valid), 72'd1);
    check("ar_first_push_data",  out_data,           72'h55);
    check("ar_first_push_ctrl",  DATA_W'(out_ctrl),  72'h22);
    drive(1'b0, 8'h00, '0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
